// File: rtl/bus_initiator_if.sv
// Host request/response and Xosera register-bus signals of one bus_initiator.
// master = initiator side; slave = requester plus bus responder side.
interface bus_initiator_if;
    logic       req_valid_i;
    logic       req_ready_o;
    logic       req_rd_nwr_i;
    logic [3:0] req_reg_num_i;
    logic       req_bytesel_i;
    logic [7:0] req_data_i;
    logic       rsp_valid_o;
    logic [7:0] rsp_data_o;
    logic       rsp_timeout_o;
    logic       bus_cs_n_o;
    logic       bus_rd_nwr_o;
    logic [3:0] bus_reg_num_o;
    logic       bus_bytesel_o;
    logic [7:0] bus_data_o;
    logic       bus_data_oe_o;
    logic [7:0] bus_data_i;
    logic       bus_dtack_n_i;

    modport master (
        input  req_valid_i, req_rd_nwr_i, req_reg_num_i, req_bytesel_i, req_data_i,
               bus_data_i, bus_dtack_n_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o,
               bus_cs_n_o, bus_rd_nwr_o, bus_reg_num_o, bus_bytesel_o, bus_data_o, bus_data_oe_o
    );

    modport slave (
        output req_valid_i, req_rd_nwr_i, req_reg_num_i, req_bytesel_i, req_data_i,
               bus_data_i, bus_dtack_n_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o,
               bus_cs_n_o, bus_rd_nwr_o, bus_reg_num_o, bus_bytesel_o, bus_data_o, bus_data_oe_o
    );
endinterface

// File: rtl/bus_initiator.sv
// Xosera register-bus initiator: one request per SETUP+ACTIVE(/DTACK)+RECOVER cycle bus access.
// Latency: CS falls SETUP_CYCLES after accept; req_ready_o stays low from accept until recovery ends.
module bus_initiator #(
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned ACTIVE_CYCLES  = 4,
    parameter int unsigned RECOVER_CYCLES = 3,
    parameter bit          USE_DTACK      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset_n_i,
    bus_initiator_if.master bi
);
    localparam logic [15:0] SETUP_N   = 16'(SETUP_CYCLES);
    localparam logic [15:0] ACTIVE_N  = 16'(ACTIVE_CYCLES);
    localparam logic [15:0] RECOVER_N = 16'(RECOVER_CYCLES);
    localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic        ready_q, ready_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_nwr_q, rd_nwr_d;
    logic [3:0]  reg_num_q, reg_num_d;
    logic        bytesel_q, bytesel_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        oe_q, oe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic        dtack_meta_q, dtack_s_q;
    logic [7:0]  data_q;
    logic        strobe_done, strobe_tmo;

    // cnt_q holds the number of edges already spent in the current state (entry loads 1).
    always_comb begin
        cnt_inc       = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        state_d       = state_q;
        cnt_d         = cnt_q;
        ready_d       = ready_q;
        cs_n_d        = cs_n_q;
        rd_nwr_d      = rd_nwr_q;
        reg_num_d     = reg_num_q;
        bytesel_d     = bytesel_q;
        wdata_d       = wdata_q;
        oe_d          = oe_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        strobe_done   = 1'b0;
        strobe_tmo    = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bi.req_valid_i && ready_q) begin
                    ready_d   = 1'b0;
                    rd_nwr_d  = bi.req_rd_nwr_i;
                    reg_num_d = bi.req_reg_num_i;
                    bytesel_d = bi.req_bytesel_i;
                    wdata_d   = bi.req_data_i;
                    oe_d      = ~bi.req_rd_nwr_i;
                    cnt_d     = 16'd1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q >= SETUP_N) begin
                    cs_n_d  = 1'b0;
                    cnt_d   = 16'd1;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            STROBE: begin
                if (USE_DTACK) begin
                    strobe_done = (cnt_q >= ACTIVE_N) && !dtack_s_q;
                    strobe_tmo  = !strobe_done && (cnt_q >= TIMEOUT_N);
                end else begin
                    strobe_done = (cnt_q >= ACTIVE_N);
                end
                if (strobe_done || strobe_tmo) begin
                    cs_n_d        = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = strobe_tmo;
                    if (rd_nwr_q) begin
                        rsp_data_d = data_q;
                    end
                    cnt_d   = 16'd1;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RECOVER: begin
                // OE already stayed up for the completion cycle, giving the write hold.
                oe_d = 1'b0;
                if ((cnt_q >= RECOVER_N && (dtack_s_q || !USE_DTACK)) || cnt_q >= TIMEOUT_N) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ready_q       <= 1'b0;
            cs_n_q        <= 1'b1;
            rd_nwr_q      <= 1'b1;
            reg_num_q     <= '0;
            bytesel_q     <= 1'b0;
            wdata_q       <= '0;
            oe_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            dtack_meta_q  <= 1'b1;
            dtack_s_q     <= 1'b1;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ready_q       <= ready_d;
            cs_n_q        <= cs_n_d;
            rd_nwr_q      <= rd_nwr_d;
            reg_num_q     <= reg_num_d;
            bytesel_q     <= bytesel_d;
            wdata_q       <= wdata_d;
            oe_q          <= oe_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            dtack_meta_q  <= bi.bus_dtack_n_i;
            dtack_s_q     <= dtack_meta_q;
            data_q        <= bi.bus_data_i;
        end
    end

    assign bi.req_ready_o   = ready_q;
    assign bi.rsp_valid_o   = rsp_valid_q;
    assign bi.rsp_data_o    = rsp_data_q;
    assign bi.rsp_timeout_o = rsp_timeout_q;
    assign bi.bus_cs_n_o    = cs_n_q;
    assign bi.bus_rd_nwr_o  = rd_nwr_q;
    assign bi.bus_reg_num_o = reg_num_q;
    assign bi.bus_bytesel_o = bytesel_q;
    assign bi.bus_data_o    = wdata_q;
    assign bi.bus_data_oe_o = oe_q;
endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: DTACK-mode instance driven from a vector table, fixed-timing instance for back-to-back.
module tb_bus_initiator;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bus_initiator_if ifd ();
    bus_initiator_if ifn ();

    bus_initiator #(.SETUP_CYCLES(2), .ACTIVE_CYCLES(4), .RECOVER_CYCLES(3),
                    .USE_DTACK(1'b1), .TIMEOUT_CYCLES(64))
        dut (.clk(clk), .reset_n_i(reset_n), .bi(ifd));

    bus_initiator #(.SETUP_CYCLES(2), .ACTIVE_CYCLES(4), .RECOVER_CYCLES(3),
                    .USE_DTACK(1'b0), .TIMEOUT_CYCLES(64))
        dut_nd (.clk(clk), .reset_n_i(reset_n), .bi(ifn));

    assign ifn.bus_dtack_n_i = 1'b1;
    assign ifn.bus_data_i    = 8'h00;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expectations pushed when a request is driven, popped on rsp_valid_o.
    typedef struct packed { logic [7:0] data; logic tmo; } rsp_t;
    rsp_t sb_q[$];
    rsp_t mon_e;
    int   rsp_seen = 0;

    always @(negedge clk) begin
        if (ifd.rsp_valid_o === 1'b1) begin
            rsp_seen++;
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_rsp: actual=rsp_valid required=none");
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_data", ifd.rsp_data_o, mon_e.data);
                chk("rsp_timeout", ifd.rsp_timeout_o, mon_e.tmo);
            end
        end
    end

    // Responder: drives read data while CS low, DTACK rsp_dly negedges after CS falls,
    // and may keep DTACK low for hold_cfg cycles after CS rises.
    int         rsp_dly = -1;
    logic [7:0] rsp_rdata = 8'h00;
    int         hold_cfg = 0;
    bit         release_now = 1'b0;
    int         low_cnt = 0;
    int         hold = 0;
    bit         was_low = 1'b0;

    always @(negedge clk) begin
        if (ifd.bus_cs_n_o === 1'b0) begin
            ifd.bus_data_i = rsp_rdata;
            if (rsp_dly >= 0 && low_cnt == rsp_dly) ifd.bus_dtack_n_i = 1'b0;
            low_cnt++;
            was_low = 1'b1;
        end else begin
            ifd.bus_data_i = 8'h00;
            if (was_low) hold = hold_cfg;
            was_low = 1'b0;
            low_cnt = 0;
            if (hold > 0 && !release_now) hold--;
            else begin
                hold = 0;
                ifd.bus_dtack_n_i = 1'b1;
            end
        end
    end

    typedef struct {
        logic       rd;
        logic [3:0] rn;
        logic       bs;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         dly;
        int         hold;
        int         exp_low;
        int         exp_rdy;
        logic [7:0] exp_rsp;
        logic       exp_to;
    } vec_t;

    vec_t vecs[9];

    task automatic wait_ready_d();
        int n = 0;
        while (ifd.req_ready_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", ifd.req_ready_o, 1'b1);
    endtask

    task automatic do_txn(input vec_t v);
        int   n;
        int   r;
        bit   oe_bad;
        bit   cs_bad;
        rsp_t e;
        repeat (2) @(negedge clk);
        release_now = 1'b0;
        rsp_dly     = v.dly;
        rsp_rdata   = v.rdata;
        hold_cfg    = v.hold;
        wait_ready_d();
        ifd.req_valid_i   = 1'b1;
        ifd.req_rd_nwr_i  = v.rd;
        ifd.req_reg_num_i = v.rn;
        ifd.req_bytesel_i = v.bs;
        ifd.req_data_i    = v.wdata;
        e.data = v.exp_rsp;
        e.tmo  = v.exp_to;
        sb_q.push_back(e);
        @(negedge clk);
        ifd.req_valid_i = 1'b0;
        chk("pin_reg", ifd.bus_reg_num_o, v.rn);
        chk("pin_bytesel", ifd.bus_bytesel_o, v.bs);
        chk("pin_rd_nwr", ifd.bus_rd_nwr_o, v.rd);
        chk("pin_data", ifd.bus_data_o, v.wdata);
        chk("pin_oe", ifd.bus_data_oe_o, !v.rd);
        chk("accept_cs_n", ifd.bus_cs_n_o, 1'b1);
        chk("accept_ready", ifd.req_ready_o, 1'b0);
        @(negedge clk);
        chk("setup_cs_n", ifd.bus_cs_n_o, 1'b1);
        @(negedge clk);
        chk("cs_fall", ifd.bus_cs_n_o, 1'b0);
        n = 1;
        oe_bad = (ifd.bus_data_oe_o !== !v.rd);
        while (n < 300) begin
            @(negedge clk);
            if (ifd.bus_cs_n_o !== 1'b0) break;
            n++;
            if (ifd.bus_data_oe_o !== !v.rd) oe_bad = 1'b1;
        end
        chk("cs_low_cycles", n, v.exp_low);
        chk("oe_during_cs", oe_bad, 1'b0);
        chk("rsp_valid_pulse", ifd.rsp_valid_o, 1'b1);
        chk("oe_hold", ifd.bus_data_oe_o, !v.rd);
        // A competing request stays pending through recovery; it must not be taken early.
        ifd.req_valid_i = 1'b1;
        r = 0;
        cs_bad = 1'b0;
        while (ifd.req_ready_o !== 1'b1 && r < 300) begin
            @(negedge clk);
            r++;
            if (r == 1) begin
                chk("rsp_valid_single", ifd.rsp_valid_o, 1'b0);
                chk("oe_drop", ifd.bus_data_oe_o, 1'b0);
            end
            if (ifd.bus_cs_n_o !== 1'b1) cs_bad = 1'b1;
        end
        ifd.req_valid_i = 1'b0;
        chk("ready_latency", r, v.exp_rdy);
        chk("no_cs_in_recover", cs_bad, 1'b0);
        chk("pins_hold", {ifd.bus_reg_num_o, ifd.bus_bytesel_o, ifd.bus_rd_nwr_o}, {v.rn, v.bs, v.rd});
        release_now = 1'b1;
    endtask

    initial begin
        int   n;
        int   base;
        bit   prev_rdy;
        bit   prev_cs;
        int   acc;
        int   falls;
        int   nlow;
        int   cur_low;
        int   pulses;
        bit   tmo_seen;
        int   fall_t[3];
        int   fall_dat[3];
        int   low_len[3];

        //            rd    rn     bs    wdata  rdata  dly hold low rdy rsp    to
        vecs[0] = '{1'b0, 4'h5, 1'b1, 8'hA5, 8'h00,  3,    0,  6,  3, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 4'hC, 1'b0, 8'h00, 8'h3C,  2,    0,  5,  3, 8'h3C, 1'b0};
        vecs[2] = '{1'b0, 4'h3, 1'b0, 8'h77, 8'hEE,  0,    0,  4,  3, 8'h3C, 1'b0};
        vecs[3] = '{1'b1, 4'h7, 1'b1, 8'h00, 8'h5A, -1,    0, 64,  3, 8'h5A, 1'b1};
        vecs[4] = '{1'b0, 4'h1, 1'b1, 8'h99, 8'h00, -1,    0, 64,  3, 8'h5A, 1'b1};
        vecs[5] = '{1'b1, 4'h2, 1'b0, 8'h00, 8'hC3,  1,    0,  4,  3, 8'hC3, 1'b0};
        vecs[6] = '{1'b0, 4'h9, 1'b0, 8'h42, 8'h00,  0,   10,  4, 13, 8'hC3, 1'b0};
        vecs[7] = '{1'b0, 4'hF, 1'b1, 8'h81, 8'h00,  0, 1000,  4, 64, 8'hC3, 1'b0};
        vecs[8] = '{1'b1, 4'h4, 1'b1, 8'h00, 8'h96,  5,    0,  8,  3, 8'h96, 1'b0};

        ifd.req_valid_i = 1'b0; ifd.req_rd_nwr_i = 1'b0; ifd.req_reg_num_i = 4'h0;
        ifd.req_bytesel_i = 1'b0; ifd.req_data_i = 8'h00;
        ifn.req_valid_i = 1'b0; ifn.req_rd_nwr_i = 1'b0; ifn.req_reg_num_i = 4'h0;
        ifn.req_bytesel_i = 1'b0; ifn.req_data_i = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_cs_n", ifd.bus_cs_n_o, 1'b1);
        chk("rst_rd_nwr", ifd.bus_rd_nwr_o, 1'b1);
        chk("rst_reg", ifd.bus_reg_num_o, 4'h0);
        chk("rst_bytesel", ifd.bus_bytesel_o, 1'b0);
        chk("rst_data", ifd.bus_data_o, 8'h00);
        chk("rst_oe", ifd.bus_data_oe_o, 1'b0);
        chk("rst_ready", ifd.req_ready_o, 1'b0);
        chk("rst_rsp_valid", ifd.rsp_valid_o, 1'b0);
        chk("rst_rsp_data", ifd.rsp_data_o, 8'h00);
        chk("rst_rsp_timeout", ifd.rsp_timeout_o, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", ifd.req_ready_o, 1'b1);

        for (int i = 0; i < 9; i++) do_txn(vecs[i]);

        // Fixed-timing instance, request held for two back-to-back writes.
        n = 0;
        while (ifn.req_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("nd_ready_wait", ifn.req_ready_o, 1'b1);
        ifn.req_valid_i = 1'b1; ifn.req_rd_nwr_i = 1'b0; ifn.req_reg_num_i = 4'h6;
        ifn.req_bytesel_i = 1'b0; ifn.req_data_i = 8'h11;
        prev_rdy = 1'b1; prev_cs = 1'b1; acc = 0; falls = 0; nlow = 0; cur_low = 0;
        pulses = 0; tmo_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin fall_t[i] = 0; fall_dat[i] = 0; low_len[i] = 0; end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (prev_rdy && ifn.req_ready_o === 1'b0) begin
                acc++;
                if (acc == 1) ifn.req_data_i = 8'h22;
                else ifn.req_valid_i = 1'b0;
            end
            if (prev_cs && ifn.bus_cs_n_o === 1'b0 && falls < 3) begin
                fall_t[falls]   = i;
                fall_dat[falls] = int'(ifn.bus_data_o);
                falls++;
            end
            if (ifn.bus_cs_n_o === 1'b0) cur_low++;
            else if (!prev_cs && nlow < 3) begin
                low_len[nlow] = cur_low;
                nlow++;
                cur_low = 0;
            end
            if (ifn.rsp_valid_o === 1'b1) begin
                pulses++;
                if (ifn.rsp_timeout_o !== 1'b0) tmo_seen = 1'b1;
            end
            prev_rdy = ifn.req_ready_o;
            prev_cs  = ifn.bus_cs_n_o;
        end
        ifn.req_valid_i = 1'b0;
        chk("b2b_accepts", acc, 2);
        chk("b2b_cs_falls", falls, 2);
        chk("b2b_first_fall", fall_t[0], 2);
        chk("b2b_fall_spacing", fall_t[1] - fall_t[0], 10);
        chk("b2b_low0", low_len[0], 4);
        chk("b2b_low1", low_len[1], 4);
        chk("b2b_data0", fall_dat[0], 8'h11);
        chk("b2b_data1", fall_dat[1], 8'h22);
        chk("b2b_pulses", pulses, 2);
        chk("b2b_timeout_flag", tmo_seen, 1'b0);

        // Reset while CS is low: cycle aborted, no response.
        repeat (2) @(negedge clk);
        release_now = 1'b0; hold_cfg = 0; rsp_dly = -1; rsp_rdata = 8'h00;
        wait_ready_d();
        ifd.req_valid_i = 1'b1; ifd.req_rd_nwr_i = 1'b0; ifd.req_reg_num_i = 4'hA;
        ifd.req_bytesel_i = 1'b1; ifd.req_data_i = 8'h5F;
        @(negedge clk);
        ifd.req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_cs_low", ifd.bus_cs_n_o, 1'b0);
        base = rsp_seen;
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", ifd.bus_cs_n_o, 1'b1);
        chk("abort_oe", ifd.bus_data_oe_o, 1'b0);
        chk("abort_ready", ifd.req_ready_o, 1'b0);
        chk("abort_rsp_valid", ifd.rsp_valid_o, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_back", ifd.req_ready_o, 1'b1);
        repeat (80) @(negedge clk);
        chk("abort_no_rsp", rsp_seen - base, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bus_initiator.md
# bus_initiator

Host-side initiator for the Xosera 8-bit register bus. It turns single-register read/write requests from an on-FPGA host (UART bridge, test sequencer, soft CPU) into properly timed `bus_cs_n`, `bus_rd_nwr`, `bus_reg_num` and `bus_bytesel` cycles with data, and completes each cycle on DTACK or a bounded timeout. It is the driving end of the protocol that Xosera's register-bus receiver decodes, and it returns read data and a completion pulse to the requester.

## Interface
- `SETUP_CYCLES`, default 2: cycles address, rd_nwr, bytesel and write data are stable before CS falls; legal range 1..255.
- `ACTIVE_CYCLES`, default 4: minimum CS-low cycles; legal range 1..255.
- `RECOVER_CYCLES`, default 3: minimum CS-high cycles before the next request is accepted; legal range 1..255.
- `USE_DTACK`, default 1: 1 = CS-low phase ends on DTACK; 0 = fixed `ACTIVE_CYCLES`.
- `TIMEOUT_CYCLES`, default 64: DTACK wait bound measured from CS fall; must exceed `ACTIVE_CYCLES`, max 65535.
- `clk` in 1: system clock.
- `reset_n_i` in 1: synchronous, active-low reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: registered; accepts a request on `req_valid_i & req_ready_o`.
- `req_rd_nwr_i` in 1: 1 = read, 0 = write.
- `req_reg_num_i` in 4: register number.
- `req_bytesel_i` in 1: 0 = even byte, 1 = odd byte.
- `req_data_i` in 8: write data.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_data_o` out 8: read data captured at completion; holds its value until the next completion.
- `rsp_timeout_o` out 1: qualifies `rsp_valid_o`; 1 = completed by timeout.
- `bus_cs_n_o` out 1: chip select, active low.
- `bus_rd_nwr_o` out 1: bus read/write.
- `bus_reg_num_o` out 4: bus register number.
- `bus_bytesel_o` out 1: bus byte select.
- `bus_data_o` out 8: write data to the bidirectional pad.
- `bus_data_oe_o` out 1: pad output enable.
- `bus_data_i` in 8: data from the pad.
- `bus_dtack_n_i` in 1: DTACK from the responder, active low, asynchronous.

## Operation
- All outputs are registered.
- **Reset values:** `bus_cs_n_o`=1, `bus_rd_nwr_o`=1, `bus_reg_num_o`=0, `bus_bytesel_o`=0, `bus_data_o`=0, `bus_data_oe_o`=0, `req_ready_o`=0, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_timeout_o`=0. State resets to IDLE.
- **Input synchronisers:**
  - `bus_dtack_n_i` passes through a 2-FF synchroniser, reset value 1; the output is `dtack_s`.
  - `bus_data_i` is registered every cycle into `data_q`.
- **IDLE:** `req_ready_o`=1. On handshake, latch the request onto the bus pins and set `bus_data_oe_o = ~req_rd_nwr_i`. Go to SETUP with `ready`=0.
- **SETUP:** count `SETUP_CYCLES`, then drive `bus_cs_n_o`=0 and go to STROBE. Clear the active counter (16-bit).
- **STROBE** completes at the first edge where either condition holds:
  - `USE_DTACK`=1: active count ≥ `ACTIVE_CYCLES` and `dtack_s`=0.
  - `USE_DTACK`=0: active count = `ACTIVE_CYCLES`.
  - Timeout instead: `USE_DTACK`=1 and active count = `TIMEOUT_CYCLES` with no DTACK. This sets `rsp_timeout_o`=1.
- **On completion:**
  - Set `bus_cs_n_o`=1 and pulse `rsp_valid_o`.
  - For reads, set `rsp_data_o <= data_q`. Reads that time out also capture `data_q`.
  - `rsp_data_o` is unchanged after writes.
  - `rsp_timeout_o` updates on every completion.
  - Go to RECOVER.
- **RECOVER:**
  - `bus_data_oe_o` stays high 1 cycle after CS rises (write hold), then drops to 0.
  - Address, bytesel and rd_nwr hold until the next accept.
  - Exit once the recover count ≥ `RECOVER_CYCLES` and `dtack_s`=1 (or `USE_DTACK`=0). If DTACK stays low, exit anyway after `TIMEOUT_CYCLES`, with no flag.
  - On exit: `req_ready_o`=1, go to IDLE.
- **Reset mid-operation:** the next edge forces the reset values. CS rises, OE drops, and no `rsp_valid_o` is produced for the aborted cycle.
- A request is never accepted while `bus_cs_n_o`=0.
- Counters saturate and never wrap.

## Timing
- Edge E0 is the accepting edge.
- After E0: bus pins valid, `bus_cs_n_o`=1.
- CS falls after edge E0+`SETUP_CYCLES`.
- With `USE_DTACK`=0: CS rises and `rsp_valid_o` pulses after edge E0+`SETUP_CYCLES`+`ACTIVE_CYCLES`.
- DTACK latency: a DTACK low arriving before edge Ek is seen as `dtack_s` after Ek+1, so CS rises after Ek+2 at the earliest.
- `req_ready_o` rises after edge Ec+`RECOVER_CYCLES`, where Ec is the completion edge.
- Back-to-back throughput with `req_valid_i` held and `USE_DTACK`=0 is one transaction per `SETUP_CYCLES`+`ACTIVE_CYCLES`+`RECOVER_CYCLES`+1 cycles (10 at defaults).
- Reset takes effect on the first edge with `reset_n_i`=0. `req_ready_o` is 1 after the first edge with `reset_n_i`=1.

## Test plan
- **Write with DTACK:** write reg 5, bytesel 1, data 0xA5; responder asserts DTACK 3 cycles after CS falls.
  - Pins 5/1/0xA5 with `rd_nwr`=0 and OE=1 from E0+1.
  - CS low from E2 until DTACK plus 2 sync cycles.
  - `rsp_valid_o` 1 cycle with `rsp_timeout_o`=0.
  - OE drops 1 cycle after CS rises.
- **Read with DTACK:** read reg 0xC, bytesel 0; responder drives 0x3C and asserts DTACK.
  - OE=0 throughout.
  - `rsp_data_o`=0x3C at the `rsp_valid_o` pulse.
- **Timeout:** responder never asserts DTACK.
  - CS stays low exactly 64 cycles.
  - `rsp_valid_o`=1 with `rsp_timeout_o`=1.
  - `req_ready_o` returns after 3 recover cycles.
- **No-DTACK back-to-back:** `USE_DTACK`=0, `req_valid_i` held for writes 0x11 then 0x22.
  - CS low exactly 4 cycles each.
  - CS falling edges 10 cycles apart.
  - Exactly two `rsp_valid_o` pulses.
- **Stuck DTACK:** DTACK held low after completion.
  - `req_ready_o` stays 0 until DTACK releases or 64 cycles elapse.
  - No second CS fall in that window.
- **Reset mid-STROBE:** `reset_n_i`=0 for 1 cycle during CS low.
  - Next edge: `bus_cs_n_o`=1, OE=0, `req_ready_o`=0.
  - No `rsp_valid_o`.
  - `req_ready_o`=1 one cycle after reset releases.
